// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor (D = A - B, LSB first) with start/done handshake.
// Optional signed-overflow output V is built when SUB_SIGNED_OVF_EN is defined.
module serial_subtractor_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CntW-1:0]  cnt_q;
`ifdef SUB_SIGNED_OVF_EN
  logic             a_msb_q;
  logic             b_msb_q;
`endif

  // Full-subtractor cell for the current bit and the shifted-in result.
  logic             bit_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  always_comb begin
    bit_d    = sa_q[0] ^ sb_q[0] ^ br_q;
    br_d     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    res_d    = {bit_d, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == LastCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      D       <= '0;
      Bout    <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      V       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        // DONE accepts a new start exactly like IDLE so operations can run back-to-back.
        StIdle, StDone: begin
          if (start) begin
            sa_q    <= A;
            sb_q    <= B;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
`ifdef SUB_SIGNED_OVF_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            D       <= res_d;
            Bout    <= br_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
`ifdef SUB_SIGNED_OVF_EN
            V       <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
`endif
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Scoreboard bench for serial_subtractor_nbit (WIDTH=8); expected results are queued at
// stimulus time and popped on each done pulse. V is checked when SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor_nbit;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
`ifdef SUB_SIGNED_OVF_EN
  logic         V;
`endif

  serial_subtractor_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .V     (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {v, bout, d}
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_d = '0;
  logic         last_bout = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    d  = a - b;
    bo = (a < b);
    v  = (a[W-1] != b[W-1]) && (a[W-1] != d[W-1]);
    return {v, bo, d};
  endfunction

  // Compare each done pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("D", {24'd0, D}, {24'd0, e[W-1:0]});
        check("Bout", {31'd0, Bout}, {31'd0, e[W]});
`ifdef SUB_SIGNED_OVF_EN
        check("V", {31'd0, V}, {31'd0, e[W+1]});
`endif
        last_d    = e[W-1:0];
        last_bout = e[W];
      end
    end
  end

  // One operation; optional spurious start pulse sampled at accept-edge + pulse_at.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at);
    int   n;
    logic busy_ok;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    n       = 1;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (n == 4) begin
        check("D_hold_in_run", {24'd0, D}, {24'd0, last_d});
        check("Bout_hold_in_run", {31'd0, Bout}, {31'd0, last_bout});
      end
      if (n == pulse_at) begin
        start = 1'b1;
        A     = 8'd9;
        B     = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("busy_during_run", {31'd0, busy_ok}, 32'd1);
    check("latency", n, W + 1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sa[3];
    logic [W-1:0] sb[3];
    int           n;
    int           prev_n;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_D", {24'd0, D}, 32'd0);
    check("rst_Bout", {31'd0, Bout}, 32'd0);
    rst = 1'b0;

    run_op(8'd5, 8'd3, 0);
    run_op(8'd3, 8'd5, 0);
    run_op(8'd0, 8'd0, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h80, 8'h01, 0);
    run_op(8'h7F, 8'hFF, 0);
    run_op(8'd200, 8'd17, 3);
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom_range(255)), W'($urandom_range(255)), 0);
    end

    // Reset mid-run: no done, outputs cleared, then a clean operation.
    @(negedge clk);
    A     = 8'h33;
    B     = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_D", {24'd0, D}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    last_d    = '0;
    last_bout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run_op(8'h10, 8'h20, 0);

    // start held high: accepts every W+1 cycles.
    sa = '{8'd40, 8'd7, 8'h81};
    sb = '{8'd2, 8'd9, 8'h02};
    @(negedge clk);
    A     = sa[0];
    B     = sb[0];
    start = 1'b1;
    exp_q.push_back(model(sa[0], sb[0]));
    n      = 0;
    prev_n = 0;
    for (int i = 0; i < 3; i++) begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        n++;
        k++;
      end while (!done && k < 40);
      check("stream_done_seen", {31'd0, done}, 32'd1);
      if (i > 0) check("stream_period", n - prev_n, W + 1);
      prev_n = n;
      if (i < 2) begin
        A = sa[i+1];
        B = sb[i+1];
        exp_q.push_back(model(sa[i+1], sb[i+1]));
      end else begin
        start = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
